// File: rtl/softmax_norm_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the softmax normalisation blocks.
package softmax_norm_pkg;

    localparam int unsigned SM_DATA_WIDTH_IN  = 16;
    localparam int unsigned SM_SUM_WIDTH      = 26;
    localparam int unsigned SM_DATA_WIDTH_OUT = 24;
    localparam int unsigned SM_IFM_SIZE       = 1000;

    typedef enum logic [1:0] {
        StIdle,
        StWaitIn,
        StDivide,
        StOutHold
    } sm_state_e;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per cycle, MSB first, dividend followed by QUOTIENT_WIDTH
// zero bits. The saturation decision is taken at start; the cycle count never changes.
module seq_divider
    import softmax_norm_pkg::*;
#(
    parameter int unsigned DIVIDEND_WIDTH = SM_DATA_WIDTH_IN,
    parameter int unsigned DIVISOR_WIDTH  = SM_SUM_WIDTH,
    parameter int unsigned QUOTIENT_WIDTH = SM_DATA_WIDTH_OUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      busy,
    output logic                      done,
    output logic [QUOTIENT_WIDTH-1:0] quotient
);

    localparam int unsigned RW = DIVISOR_WIDTH + 1;
    localparam int unsigned CW = cnt_width(QUOTIENT_WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(QUOTIENT_WIDTH - 1);

    logic [RW-1:0]             num_q;
    logic [RW-1:0]             rem_q;
    logic [QUOTIENT_WIDTH-1:0] quo_q;
    logic [CW-1:0]             cnt_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      sat_q;

    logic [RW-1:0] partial;
    logic [RW-1:0] shifted;
    logic [RW-1:0] den_ext;
    logic          fits;
    logic [RW-1:0] rem_next;

    // With dividend < divisor the leading dividend bits all yield zero quotient bits, so the
    // first iteration starts from the dividend itself as the partial remainder.
    always_comb begin
        partial  = (cnt_q == '0) ? num_q : rem_q;
        shifted  = {partial[RW-2:0], 1'b0};
        den_ext  = {1'b0, divisor};
        fits     = partial[RW-1] | (shifted >= den_ext);
        rem_next = fits ? (shifted - den_ext) : shifted;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                num_q  <= RW'(dividend);
                rem_q  <= '0;
                cnt_q  <= '0;
                busy_q <= 1'b1;
                sat_q  <= (divisor == '0) || (RW'(dividend) >= RW'(divisor));
            end else if (busy_q) begin
                rem_q <= rem_next;
                quo_q <= {quo_q[QUOTIENT_WIDTH-2:0], fits};
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = sat_q ? '1 : quo_q;

endmodule

// File: rtl/softmax_norm.sv
// Softmax normaliser: divides each exponent of a frame by the frame's exponent sum, one element
// in flight, producing saturated Q0.DATA_WIDTH_OUT probabilities with valid/ready handshakes.
module softmax_norm
    import softmax_norm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_IN  = SM_DATA_WIDTH_IN,
    parameter int unsigned SUM_WIDTH      = SM_SUM_WIDTH,
    parameter int unsigned DATA_WIDTH_OUT = SM_DATA_WIDTH_OUT,
    parameter int unsigned IFM_SIZE       = SM_IFM_SIZE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sum_valid,
    input  logic [SUM_WIDTH-1:0]      sum_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH_IN-1:0]  exp_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH_OUT-1:0] softmax_out,
    output logic                      last,
    output logic                      div_err
);

    localparam int unsigned CNT_W = cnt_width(IFM_SIZE);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IFM_SIZE - 1);

    sm_state_e                 state;
    logic [CNT_W-1:0]          elem_cnt;
    logic [SUM_WIDTH-1:0]      sum_q;
    logic                      div_start;
    logic                      div_busy;
    logic                      div_done;
    logic [DATA_WIDTH_OUT-1:0] div_quotient;

    assign div_start = (state == StWaitIn) && in_valid && in_ready;

    seq_divider #(
        .DIVIDEND_WIDTH (DATA_WIDTH_IN),
        .DIVISOR_WIDTH  (SUM_WIDTH),
        .QUOTIENT_WIDTH (DATA_WIDTH_OUT)
    ) u_seq_divider (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (exp_in),
        .divisor  (sum_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            last        <= 1'b0;
            div_err     <= 1'b0;
            softmax_out <= '0;
            elem_cnt    <= '0;
            sum_q       <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (sum_valid) begin
                        sum_q    <= sum_in;
                        elem_cnt <= '0;
                        in_ready <= 1'b1;
                        state    <= StWaitIn;
                        if (sum_in == '0) begin
                            div_err <= 1'b1;
                        end
                    end
                end
                StWaitIn: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        state    <= StDivide;
                    end
                end
                StDivide: begin
                    if (div_done && !div_busy) begin
                        softmax_out <= div_quotient;
                        out_valid   <= 1'b1;
                        last        <= (elem_cnt == LAST_IDX);
                        state       <= StOutHold;
                    end
                end
                StOutHold: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        last      <= 1'b0;
                        if (elem_cnt == LAST_IDX) begin
                            elem_cnt <= '0;
                            state    <= StIdle;
                        end else begin
                            elem_cnt <= elem_cnt + CNT_W'(1);
                            in_ready <= 1'b1;
                            state    <= StWaitIn;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_norm.sv
// Directed bench for softmax_norm with a scoreboard of expected quotients and last flags.
module tb_softmax_norm;

    localparam int unsigned DW_IN  = 16;
    localparam int unsigned SW     = 26;
    localparam int unsigned DW_OUT = 24;
    localparam int unsigned FRAME  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              sum_valid;
    logic [SW-1:0]     sum_in;
    logic              in_valid;
    logic              in_ready;
    logic [DW_IN-1:0]  exp_in;
    logic              out_valid;
    logic              out_ready;
    logic [DW_OUT-1:0] softmax_out;
    logic              last;
    logic              div_err;

    typedef struct {
        logic [DW_OUT-1:0] data;
        logic              last;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   acc_edge = 0;
    logic prev_ov = 1'b0;

    softmax_norm #(
        .DATA_WIDTH_IN  (DW_IN),
        .SUM_WIDTH      (SW),
        .DATA_WIDTH_OUT (DW_OUT),
        .IFM_SIZE       (FRAME)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sum_valid   (sum_valid),
        .sum_in      (sum_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .exp_in      (exp_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .softmax_out (softmax_out),
        .last        (last),
        .div_err     (div_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW_OUT-1:0] model(input logic [DW_IN-1:0] e, input logic [SW-1:0] s);
        longint unsigned n;
        if (s == 0 || 32'(e) >= 32'(s)) return '1;
        n = longint'(e) << DW_OUT;
        return DW_OUT'(n / longint'(s));
    endfunction

    // Output monitor: pops on every output transfer and checks first-valid latency.
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov && q.size() != 0)
                check("latency", 32'(cyc - acc_edge), 32'd25);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    check("softmax_out", 32'(softmax_out), 32'(x.data));
                    check("last", 32'(last), 32'(x.last));
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic load(input logic [SW-1:0] s);
        @(posedge clk); #1;
        sum_valid = 1'b1;
        sum_in    = s;
        @(posedge clk); #1;
        sum_valid = 1'b0;
    endtask

    task automatic send(input logic [DW_IN-1:0] e, input logic [SW-1:0] s, input int idx);
        exp_t x;
        int   n = 0;
        in_valid = 1'b1;
        exp_in   = e;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept", 32'(in_ready), 32'd1);
        x.data = model(e, s);
        x.last = (idx == FRAME - 1);
        q.push_back(x);
        acc_edge = cyc + 1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic frame(input logic [SW-1:0] s, input logic [DW_IN-1:0] e0, input logic [DW_IN-1:0] e1,
                         input logic [DW_IN-1:0] e2, input logic [DW_IN-1:0] e3);
        logic [DW_IN-1:0] es[4];
        es = '{e0, e1, e2, e3};
        load(s);
        for (int i = 0; i < 4; i++) begin
            send(es[i], s, i);
            drain();
        end
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        int ov_cnt;
        rst = 1'b1; sum_valid = 1'b0; sum_in = '0; in_valid = 1'b0; exp_in = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        check("rst_div_err", 32'(div_err), 32'd0);
        check("rst_softmax_out", 32'(softmax_out), 32'd0);

        frame(26'd4, 16'd1, 16'd2, 16'd3, 16'd4);
        frame(26'd100, 16'd100, 16'd0, 16'd50, 16'd99);
        frame(26'd3, 16'd1, 16'd2, 16'd3, 16'd1);

        // sum=10 frame with a stalled output and a mid-frame sum_valid that must be ignored
        load(26'd10);
        send(16'd1, 26'd10, 0);
        drain();
        sum_valid = 1'b1; sum_in = 26'd7;
        @(posedge clk); #1 sum_valid = 1'b0;
        out_ready = 1'b0;
        send(16'd2, 26'd10, 1);
        for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(softmax_out), 32'(model(16'd2, 26'd10)));
            check("stall_last", 32'(last), 32'd0);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        drain();
        send(16'd3, 26'd10, 2);
        drain();
        send(16'd4, 26'd10, 3);
        drain();
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd0);
        check("div_err_clear", 32'(div_err), 32'd0);

        frame(26'd0, 16'd5, 16'd0, 16'd7, 16'd1);
        check("div_err_sticky", 32'(div_err), 32'd1);

        // Reset five cycles into DIVIDE
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        load(26'd10);
        send(16'd3, 26'd10, 0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        q.delete();
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_last", 32'(last), 32'd0);
        check("mid_rst_div_err", 32'(div_err), 32'd0);
        check("mid_rst_softmax_out", 32'(softmax_out), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        ov_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        check("no_spurious_valid", 32'(ov_cnt), 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/softmax_norm.md
SOFTMAX_NORM -- requirements
Module: softmax_norm

Interface
REQ-001 Parameter DATA_WIDTH_IN, default 16: width of each unsigned exponent value (numerator).
REQ-002 Parameter SUM_WIDTH, default 26: width of the unsigned exponent sum (denominator).
REQ-003 Parameter DATA_WIDTH_OUT, default 24: width of the unsigned Q0.DATA_WIDTH_OUT probability output.
REQ-004 Parameter IFM_SIZE, default 1000: number of elements per frame.
REQ-005 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous, active-high.
REQ-007 Port sum_valid, input, 1: sum_in is valid; it is consumed only in IDLE.
REQ-008 Port sum_in, input, SUM_WIDTH: frame denominator.
REQ-009 Port in_valid / in_ready, input / output, 1 each: numerator handshake; a transfer occurs when both are high at a clock edge.
REQ-010 Port exp_in, input, DATA_WIDTH_IN: numerator.
REQ-011 Port out_valid / out_ready, output / input, 1 each: result handshake.
REQ-012 Port softmax_out, output, DATA_WIDTH_OUT: quotient floor(exp_in * 2^DATA_WIDTH_OUT / sum_in), saturated.
REQ-013 Port last, output, 1: high with the result of the IFM_SIZE-th element of a frame.
REQ-014 Port div_err, output, 1: sticky flag, set when a frame is loaded with sum_in == 0.

Function
REQ-015 FSM states: IDLE, WAIT_IN, DIVIDE, OUT_HOLD.
REQ-016 IDLE: when sum_valid is high, latch sum_in, clear elem_cnt, go to WAIT_IN; in_ready=0, out_valid=0.
REQ-017 WAIT_IN: in_ready=1; on transfer, latch exp_in, load remainder=0, clear the iteration counter, go to DIVIDE.
REQ-018 DIVIDE: restoring division, one quotient bit per cycle, MSB first, over the dividend exp_in followed by DATA_WIDTH_OUT zero bits; exactly DATA_WIDTH_OUT cycles; remainder register is SUM_WIDTH+1 bits.
REQ-019 Saturation: if exp_in >= latched sum, or latched sum == 0, softmax_out is all ones; the saturation decision is made at load time, and the DIVIDE cycle count is unchanged.
REQ-020 Latency: out_valid rises exactly DATA_WIDTH_OUT+1 clock edges after the accepting edge (25 for the default); the FSM then enters OUT_HOLD.
REQ-021 OUT_HOLD: out_valid=1; softmax_out and last are held stable until out_ready is high at an edge.
REQ-022 On the output transfer, elem_cnt increments; if it was IFM_SIZE-1, go to IDLE, otherwise go to WAIT_IN.
REQ-023 last = out_valid AND (elem_cnt == IFM_SIZE-1).
REQ-024 sum_valid is ignored outside IDLE.
REQ-025 in_ready is 0 in DIVIDE and OUT_HOLD; one element is in flight at most.
REQ-026 div_err is set on the IDLE load with sum_in == 0 and is cleared only by rst.
REQ-027 elem_cnt width is clog2(IFM_SIZE); it never exceeds IFM_SIZE-1.

Reset
REQ-028 While rst is high at an edge, the FSM goes to IDLE, and in_ready, out_valid, last and div_err go to 0.
REQ-029 While rst is high at an edge, softmax_out, elem_cnt, the latched sum and the remainder go to 0.
REQ-030 Reset mid-DIVIDE or mid-OUT_HOLD abandons the element and frame; no out_valid follows.
REQ-031 rst has priority over every other input in the same cycle.

Structure
REQ-032 A shared package holds the FSM state enum and the default width and IFM_SIZE constants used across the softmax blocks.
REQ-033 One sub-module, seq_divider, holds the restoring-divider datapath (start, busy, done, quotient); the FSM, counters and handshakes stay in softmax_norm.

Verification
REQ-034 sum=4, exp=1, out_ready=1 -> softmax_out=0x400000 exactly 25 edges after acceptance, last=0.
REQ-035 sum=100, exp=100 -> 0xFFFFFF; sum=3, exp=1 -> 0x555555.
REQ-036 sum=0 load, exp=5 -> softmax_out=0xFFFFFF and div_err=1 until rst.
REQ-037 out_ready held low for 10 cycles during OUT_HOLD -> out_valid, softmax_out and last stable, in_ready=0, nothing lost.
REQ-038 IFM_SIZE=4, sum=10, exps 1,2,3,4 -> 0x199999, 0x333333, 0x4CCCCC, 0x666666; last only on the 4th; return to IDLE; sum_valid mid-frame ignored.
REQ-039 rst asserted 5 cycles into DIVIDE -> all outputs 0 on the next edge, IDLE, and no spurious out_valid afterwards.
